aes_inv_cipher_iter: RTL and testbench

Iterative, parameterised AES inverse cipher engine. It decrypts one 128-bit block over NR+1 clock cycles using a single shared inverse-round datapath, and supports AES-128, AES-192 and AES-256 through the NR parameter. It sits between the ciphertext source and the plaintext sink. Round keys come from an external key-schedule memory, which this block indexes directly. It replaces the unrolled, purely combinational round chain with a registered, handshaked core.

---
 rtl/aes_inv_cipher_iter_if.sv | 43 ++++
 rtl/aes_inv_cipher_iter.sv | 178 +++++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_cipher_iter_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_cipher_iter_if
// Purpose  : Bundles the ciphertext input handshake, the plaintext output
//            handshake and the round-key lookup of aes_inv_cipher_iter.
// Signals  : in_valid/in_ready/in_data   ciphertext handshake (128-bit data)
//            out_valid/out_ready/out_data plaintext handshake (128-bit data)
//            rk_idx (4)  round key index requested by the core
//            rk (128)    round key returned by the key-schedule memory
//            abort       cancel request, only with AES_INV_ABORT_EN
// Modports : master = environment (source, sink, key memory), slave = core
// Revision : 1.0  initial release
// ============================================================================
interface aes_inv_cipher_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef AES_INV_ABORT_EN
  logic         abort;
`endif

  modport master (
    output in_valid, in_data, rk, out_ready,
`ifdef AES_INV_ABORT_EN
    output abort,
`endif
    input  in_ready, rk_idx, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, rk, out_ready,
`ifdef AES_INV_ABORT_EN
    input  abort,
`endif
    output in_ready, rk_idx, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/aes_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_cipher_iter
// Purpose  : Iterative AES inverse cipher. One 128-bit block is decrypted over
//            NR+1 clock edges through a single shared inverse-round datapath.
//            NR = 10/12/14 selects AES-128/192/256.
// Ports    : clk        rising-edge clock
//            rst        synchronous active-high reset
//            bus        aes_inv_cipher_iter_if.slave (ciphertext in, plaintext
//                       out, round-key index out / round key in)
// Options  : AES_INV_ABORT_EN adds the bus.abort cancel input.
// Revision : 1.0  initial release
// ============================================================================
module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input wire                    clk,
  input wire                    rst,
  aes_inv_cipher_iter_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [3:0] RC_INIT  = 4'(NR);
  localparam logic [3:0] RC_FIRST = 4'(NR - 1);

  generate
    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
      $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
    end
  endgenerate

  // Inverse S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Returns {b*0e, b*0b, b*0d, b*09} in GF(2^8).
  function automatic logic [31:0] inv_muls(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x2 ^ b, x8 ^ x4 ^ b, x8 ^ b};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [31:0] m0, m1, m2, m3;
    m0 = inv_muls(a[31:24]);
    m1 = inv_muls(a[23:16]);
    m2 = inv_muls(a[15:8]);
    m3 = inv_muls(a[7:0]);
    // field order in m*: [31:24]=0e [23:16]=0b [15:8]=0d [7:0]=09
    return {m0[31:24] ^ m1[23:16] ^ m2[15:8]  ^ m3[7:0],
            m0[7:0]   ^ m1[31:24] ^ m2[23:16] ^ m3[15:8],
            m0[15:8]  ^ m1[7:0]   ^ m2[31:24] ^ m3[23:16],
            m0[23:16] ^ m1[15:8]  ^ m2[7:0]   ^ m3[31:24]};
  endfunction

  logic [1:0]   state;
  logic [127:0] st;
  logic [3:0]   rc;
  logic         cancel;

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;
  logic [127:0] mixed;

`ifdef AES_INV_ABORT_EN
  assign cancel = bus.abort;
`else
  assign cancel = 1'b0;
`endif

  // Byte i of the state sits at row i%4, column i/4. InvShiftRows rotates
  // row r right by r columns; each byte then goes through its own S-box.
  generate
    for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
        localparam int DST = r + 4 * c;
        localparam int SRC = r + 4 * ((c - r + 4) % 4);
        assign shifted[127 - 8*DST -: 8] = st[127 - 8*SRC -: 8];
        assign subbed[127 - 8*DST -: 8]  = inv_sbox(shifted[127 - 8*DST -: 8]);
      end
    end
  endgenerate

  assign keyed = subbed ^ bus.rk;

  generate
    for (genvar c = 0; c < 4; c++) begin : g_mix
      assign mixed[127 - 32*c -: 32] = inv_mix_col(keyed[127 - 32*c -: 32]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      st    <= '0;
      rc    <= RC_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && !cancel) begin
            st    <= bus.in_data ^ bus.rk;
            rc    <= RC_FIRST;
            state <= ROUND;
          end
        end
        ROUND: begin
          if (cancel) begin
            rc    <= RC_INIT;
            state <= IDLE;
          end else begin
            st <= mixed;
            rc <= rc - 4'd1;
            if (rc == 4'd1) begin
              state <= FINAL;
            end
          end
        end
        FINAL: begin
          if (cancel) begin
            rc    <= RC_INIT;
            state <= IDLE;
          end else begin
            st    <= keyed;
            state <= DONE;
          end
        end
        DONE: begin
          if (cancel || bus.out_ready) begin
            rc    <= RC_INIT;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Key index depends only on registered state, so a key RAM sharing this
  // clock sees a stable address for the whole cycle.
  assign bus.rk_idx    = (state == IDLE)  ? RC_INIT :
                         (state == FINAL) ? 4'd0    : rc;
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = st;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_inv_cipher_iter
// Purpose  : Self-checking bench for aes_inv_cipher_iter. Three cores (NR =
//            10, 12, 14) each read their own key schedule array. Expected
//            plaintexts come from the FIPS-197 vectors and from a forward AES
//            model: random plaintext is encrypted by the model and the core
//            must recover it.
// Options  : AES_INV_ABORT_EN enables the abort sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_aes_inv_cipher_iter;

  logic clk;
  logic rst;

  logic         in_valid  [3];
  logic [127:0] in_data   [3];
  logic         out_ready [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic [3:0]   rk_idx    [3];
  logic [127:0] out_data  [3];
  logic [127:0] ks        [3][16];
`ifdef AES_INV_ABORT_EN
  logic         abort     [3];
`endif

  logic [7:0] sb [256];
  int n_pass  = 0;
  int n_total = 0;

  generate
    for (genvar k = 0; k < 3; k++) begin : g_dut
      aes_inv_cipher_iter_if bus ();
      assign bus.in_valid  = in_valid[k];
      assign bus.in_data   = in_data[k];
      assign bus.out_ready = out_ready[k];
      assign bus.rk        = ks[k][bus.rk_idx];
`ifdef AES_INV_ABORT_EN
      assign bus.abort     = abort[k];
`endif
      assign in_ready[k]   = bus.in_ready;
      assign out_valid[k]  = bus.out_valid;
      assign rk_idx[k]     = bus.rk_idx;
      assign out_data[k]   = bus.out_data;
      aes_inv_cipher_iter #(.NR(10 + 2*k)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic key_expand(input int k, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk, nr;
    nk = 4 + 2*k; nr = 10 + 2*k; rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) ks[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input int k, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    int nr;
    nr = 10 + 2*k;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[k][0][127-8*i -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row + 4*c] = t[row + 4*((c + row) % 4)];
      if (rnd < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[k][rnd][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic start_block(input int k, input logic [127:0] ct, input string tag);
    check($sformatf("%s idle in_ready", tag), 128'(in_ready[k]), 128'(1));
    check($sformatf("%s idle rk_idx", tag), 128'(rk_idx[k]), 128'(10 + 2*k));
    in_valid[k] = 1'b1;
    in_data[k]  = ct;
    @(negedge clk);
    in_valid[k] = 1'b0;
    in_data[k]  = rand128();
  endtask

  // Called on the first negedge after the accept edge.
  task automatic finish_block(input int k, input logic [127:0] pt, input int hold, input string tag);
    int j, nr;
    nr = 10 + 2*k;
    j = 0;
    while (!out_valid[k] && j < 4*nr) begin
      check($sformatf("%s rk_idx@%0d", tag, j), 128'(rk_idx[k]), 128'(nr - 1 - j));
      @(negedge clk);
      j++;
    end
    check($sformatf("%s latency", tag), 128'(j), 128'(nr));
    check($sformatf("%s out_data", tag), out_data[k], pt);
    check($sformatf("%s busy in_ready", tag), 128'(in_ready[k]), 128'(0));
    for (int h = 0; h < hold; h++) begin
      in_valid[k] = (h % 2 == 0);
      in_data[k]  = rand128();
      @(negedge clk);
      check($sformatf("%s hold%0d out_valid", tag, h), 128'(out_valid[k]), 128'(1));
      check($sformatf("%s hold%0d out_data", tag, h), out_data[k], pt);
      check($sformatf("%s hold%0d in_ready", tag, h), 128'(in_ready[k]), 128'(0));
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    check($sformatf("%s post out_valid", tag), 128'(out_valid[k]), 128'(0));
    check($sformatf("%s post in_ready", tag), 128'(in_ready[k]), 128'(1));
  endtask

  task automatic run_block(input int k, input logic [127:0] ct, input logic [127:0] pt,
                           input int hold, input string tag);
    start_block(k, ct, tag);
    finish_block(k, pt, hold, tag);
  endtask

  typedef struct {
    int           k;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           hold;
  } vec_t;

  localparam logic [255:0] KEY128 = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
  localparam logic [255:0] KEY192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  vec_t vecs [9];

  initial begin
    int cnt, last, cyc, seen;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; out_ready[k] = 1'b0;
`ifdef AES_INV_ABORT_EN
      abort[k] = 1'b0;
`endif
      for (int r = 0; r < 16; r++) ks[k][r] = '0;
    end
    build_sbox();

    // Vector table: FIPS-197 known answers plus model-generated random blocks.
    vecs[0] = '{0, KEY128, C1_CT, FIPS_PT, 0};
    vecs[1] = '{1, KEY192, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, FIPS_PT, 0};
    vecs[2] = '{2, KEY256, 128'h8ea2b7ca516745bfeafc49904b496089, FIPS_PT, 0};
    for (int i = 3; i < 9; i++) begin
      vecs[i].k    = (i - 3) % 3;
      vecs[i].key  = {rand128(), rand128()};
      vecs[i].pt   = rand128();
      vecs[i].hold = int'($urandom_range(0, 3));
      key_expand(vecs[i].k, vecs[i].key);
      vecs[i].ct   = encrypt(vecs[i].k, vecs[i].pt);
    end

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset%0d in_ready", k), 128'(in_ready[k]), 128'(1));
      check($sformatf("reset%0d out_valid", k), 128'(out_valid[k]), 128'(0));
      check($sformatf("reset%0d rk_idx", k), 128'(rk_idx[k]), 128'(10 + 2*k));
      check($sformatf("reset%0d out_data", k), out_data[k], 128'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      key_expand(vecs[i].k, vecs[i].key);
      run_block(vecs[i].k, vecs[i].ct, vecs[i].pt, vecs[i].hold, $sformatf("vec%0d", i));
    end

    // Backpressure in DONE, then a second block.
    key_expand(0, KEY128);
    run_block(0, C1_CT, FIPS_PT, 5, "bp1");
    run_block(0, C1_CT, FIPS_PT, 0, "bp2");

    // Reset on the fourth ROUND cycle.
    start_block(0, C1_CT, "rstmid");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid in_ready", 128'(in_ready[0]), 128'(1));
    check("rstmid out_valid", 128'(out_valid[0]), 128'(0));
    check("rstmid rk_idx", 128'(rk_idx[0]), 128'(10));
    check("rstmid st", out_data[0], 128'h0);
    @(negedge clk);
    run_block(0, C1_CT, FIPS_PT, 0, "after_rst");

    // Streaming: source always valid, sink always ready.
    in_valid[0] = 1'b1; in_data[0] = C1_CT; out_ready[0] = 1'b1;
    cnt = 0; last = 0;
    for (cyc = 0; cyc < 200 && cnt < 4; cyc++) begin
      @(negedge clk);
      if (out_valid[0]) begin
        check($sformatf("stream%0d data", cnt), out_data[0], FIPS_PT);
        if (cnt > 0) check($sformatf("stream%0d spacing", cnt), 128'(cyc - last), 128'(12));
        last = cyc;
        cnt++;
        if (cnt == 4) in_valid[0] = 1'b0;
      end
    end
    check("stream count", 128'(cnt), 128'(4));
    in_valid[0] = 1'b0;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("stream idle", 128'(in_ready[0]), 128'(1));

`ifdef AES_INV_ABORT_EN
    // Abort on the third round.
    start_block(0, C1_CT, "abr");
    repeat (2) @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    check("abort round in_ready", 128'(in_ready[0]), 128'(1));
    check("abort round out_valid", 128'(out_valid[0]), 128'(0));
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1;
    end
    check("abort round no output", 128'(seen), 128'(0));

    // Abort in DONE.
    start_block(0, C1_CT, "abd");
    cyc = 0;
    while (!out_valid[0] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("abort done reached", 128'(out_valid[0]), 128'(1));
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    check("abort done out_valid", 128'(out_valid[0]), 128'(0));
    check("abort done in_ready", 128'(in_ready[0]), 128'(1));

    // Abort together with in_valid in IDLE: no accept.
    abort[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = C1_CT;
    @(negedge clk);
    abort[0] = 1'b0; in_valid[0] = 1'b0;
    check("abort idle in_ready", 128'(in_ready[0]), 128'(1));
    check("abort idle rk_idx", 128'(rk_idx[0]), 128'(10));
    run_block(0, C1_CT, FIPS_PT, 0, "after_abort");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
